// File: rtl/bsg_axil_csr_bank.sv
// bsg_axil_csr_bank: AXI-Lite slave register bank.
// Holds num_regs_p CSRs, word-addressed from base_addr_p, drives them flat on
// csr_o, and pulses csr_w_v_o[i] the cycle after CSR i accepts a write.
// One outstanding write and one outstanding read, each owned by its own FSM.
//
// Optional build macro: BSG_AXIL_CSR_BANK_STRICT_ALIGN_EN
//   defined   -> accesses with nonzero low (sub-word) address bits get SLVERR
//   undefined -> low address bits are ignored (unaligned hits containing word)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// e_idle   | write FSM: waiting for AW and W together; read FSM: AR ready
// e_bresp  | write FSM: B response held until bready
// e_rresp  | read FSM: R response held until rready

module bsg_axil_csr_bank #(
  parameter int          addr_width_p = 32,
  parameter int          data_width_p = 32,
  parameter int          num_regs_p   = 8,
  parameter int unsigned base_addr_p  = 0
) (
  input  logic                               clk_i,
  input  logic                               reset_i,

  input  logic [addr_width_p-1:0]            s00_axil_awaddr,
  input  logic [2:0]                         s00_axil_awprot,
  input  logic                               s00_axil_awvalid,
  output logic                               s00_axil_awready,

  input  logic [data_width_p-1:0]            s00_axil_wdata,
  input  logic [data_width_p/8-1:0]          s00_axil_wstrb,
  input  logic                               s00_axil_wvalid,
  output logic                               s00_axil_wready,

  output logic [1:0]                         s00_axil_bresp,
  output logic                               s00_axil_bvalid,
  input  logic                               s00_axil_bready,

  input  logic [addr_width_p-1:0]            s00_axil_araddr,
  input  logic [2:0]                         s00_axil_arprot,
  input  logic                               s00_axil_arvalid,
  output logic                               s00_axil_arready,

  output logic [data_width_p-1:0]            s00_axil_rdata,
  output logic [1:0]                         s00_axil_rresp,
  output logic                               s00_axil_rvalid,
  input  logic                               s00_axil_rready,

  output logic [num_regs_p*data_width_p-1:0] csr_o,
  output logic [num_regs_p-1:0]              csr_w_v_o
);

  localparam int strb_w_lp = data_width_p / 8;
  localparam int lg_b_lp   = $clog2(strb_w_lp);
  localparam int idx_w_lp  = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;
  localparam logic [addr_width_p-1:0] base_lp  = addr_width_p'(base_addr_p);
  localparam logic [addr_width_p-1:0] nregs_lp = addr_width_p'(num_regs_p);
  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_slverr_lp = 2'b10;

  // Shared literal set; the write FSM uses e_idle/e_bresp, the read FSM
  // uses e_idle/e_rresp.
  typedef enum logic [1:0] {e_idle, e_bresp, e_rresp} state_e;

  state_e wr_state_r, wr_state_n;
  state_e rd_state_r, rd_state_n;

  logic [data_width_p-1:0] csr_r [num_regs_p];
  logic [num_regs_p-1:0]   csr_w_v_r;
  logic [1:0]              bresp_r;
  logic [1:0]              rresp_r;
  logic [data_width_p-1:0] rdata_r;

  logic [addr_width_p-1:0] aw_off, aw_word, ar_off, ar_word;
  logic                    aw_hit, ar_hit;
  logic [idx_w_lp-1:0]     aw_idx, ar_idx;
  logic                    wr_hs, rd_hs;

  // Protection bits carry no meaning for this bank.
  logic unused_prot;
  assign unused_prot = ^{s00_axil_awprot, s00_axil_arprot};

  // Decode write and read addresses into hit flag and CSR index.
  always_comb begin
    aw_off  = s00_axil_awaddr - base_lp;
    aw_word = aw_off >> lg_b_lp;
    aw_hit  = (s00_axil_awaddr >= base_lp) && (aw_word < nregs_lp);
    ar_off  = s00_axil_araddr - base_lp;
    ar_word = ar_off >> lg_b_lp;
    ar_hit  = (s00_axil_araddr >= base_lp) && (ar_word < nregs_lp);
`ifdef BSG_AXIL_CSR_BANK_STRICT_ALIGN_EN
    aw_hit  = aw_hit && (s00_axil_awaddr[lg_b_lp-1:0] == '0);
    ar_hit  = ar_hit && (s00_axil_araddr[lg_b_lp-1:0] == '0);
`endif
    aw_idx  = aw_word[idx_w_lp-1:0];
    ar_idx  = ar_word[idx_w_lp-1:0];
  end

  // Write FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) wr_state_r <= e_idle;
    else         wr_state_r <= wr_state_n;
  end

  // Write FSM next state and handshake outputs; AW and W accepted together only.
  always_comb begin
    wr_state_n       = wr_state_r;
    s00_axil_awready = 1'b0;
    s00_axil_wready  = 1'b0;
    s00_axil_bvalid  = 1'b0;
    wr_hs            = 1'b0;
    case (wr_state_r)
      e_idle: begin
        wr_hs            = s00_axil_awvalid & s00_axil_wvalid;
        s00_axil_awready = wr_hs;
        s00_axil_wready  = wr_hs;
        if (wr_hs) wr_state_n = e_bresp;
      end
      e_bresp: begin
        s00_axil_bvalid = 1'b1;
        if (s00_axil_bready) wr_state_n = e_idle;
      end
      default: wr_state_n = e_idle;
    endcase
  end

  // CSR storage, byte-strobed update, update pulse and write response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_regs_p; i++) csr_r[i] <= '0;
      csr_w_v_r <= '0;
      bresp_r   <= '0;
    end else begin
      csr_w_v_r <= '0;
      if (wr_hs) begin
        bresp_r <= aw_hit ? resp_okay_lp : resp_slverr_lp;
        if (aw_hit) begin
          csr_w_v_r[aw_idx] <= 1'b1;
          for (int k = 0; k < strb_w_lp; k++) begin
            if (s00_axil_wstrb[k]) csr_r[aw_idx][8*k +: 8] <= s00_axil_wdata[8*k +: 8];
          end
        end
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) rd_state_r <= e_idle;
    else         rd_state_r <= rd_state_n;
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    rd_state_n       = rd_state_r;
    s00_axil_arready = 1'b0;
    s00_axil_rvalid  = 1'b0;
    rd_hs            = 1'b0;
    case (rd_state_r)
      e_idle: begin
        s00_axil_arready = 1'b1;
        rd_hs            = s00_axil_arvalid;
        if (rd_hs) rd_state_n = e_rresp;
      end
      e_rresp: begin
        s00_axil_rvalid = 1'b1;
        if (s00_axil_rready) rd_state_n = e_idle;
      end
      default: rd_state_n = e_idle;
    endcase
  end

  // Read data capture; sees the CSR value from before any same-cycle write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_r <= '0;
      rresp_r <= '0;
    end else if (rd_hs) begin
      rdata_r <= ar_hit ? csr_r[ar_idx] : '0;
      rresp_r <= ar_hit ? resp_okay_lp : resp_slverr_lp;
    end
  end

  for (genvar g = 0; g < num_regs_p; g++) begin : g_flat
    assign csr_o[g*data_width_p +: data_width_p] = csr_r[g];
  end

  assign csr_w_v_o      = csr_w_v_r;
  assign s00_axil_bresp = bresp_r;
  assign s00_axil_rresp = rresp_r;
  assign s00_axil_rdata = rdata_r;

endmodule

// File: tb/tb_bsg_axil_csr_bank.sv
// Bench for bsg_axil_csr_bank: directed AXI-Lite transactions, a transaction-
// level model of the register bank compared every cycle, plus literal checks.
module tb_bsg_axil_csr_bank;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int unsigned BASE = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]    awaddr = '0;
  logic [2:0]       awprot = '0;
  logic             awvalid = 1'b0, awready;
  logic [DW-1:0]    wdata = '0;
  logic [DW/8-1:0]  wstrb = '0;
  logic             wvalid = 1'b0, wready;
  logic [1:0]       bresp;
  logic             bvalid, bready = 1'b1;
  logic [AW-1:0]    araddr = '0;
  logic [2:0]       arprot = '0;
  logic             arvalid = 1'b0, arready;
  logic [DW-1:0]    rdata;
  logic [1:0]       rresp;
  logic             rvalid, rready = 1'b1;
  logic [NR*DW-1:0] csr_o;
  logic [NR-1:0]    csr_w_v_o;

  bsg_axil_csr_bank #(.addr_width_p(AW), .data_width_p(DW), .num_regs_p(NR), .base_addr_p(BASE)) dut (
    .clk_i(clk), .reset_i(reset),
    .s00_axil_awaddr(awaddr), .s00_axil_awprot(awprot), .s00_axil_awvalid(awvalid), .s00_axil_awready(awready),
    .s00_axil_wdata(wdata), .s00_axil_wstrb(wstrb), .s00_axil_wvalid(wvalid), .s00_axil_wready(wready),
    .s00_axil_bresp(bresp), .s00_axil_bvalid(bvalid), .s00_axil_bready(bready),
    .s00_axil_araddr(araddr), .s00_axil_arprot(arprot), .s00_axil_arvalid(arvalid), .s00_axil_arready(arready),
    .s00_axil_rdata(rdata), .s00_axil_rresp(rresp), .s00_axil_rvalid(rvalid), .s00_axil_rready(rready),
    .csr_o(csr_o), .csr_w_v_o(csr_w_v_o)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transaction-level model: register array plus "response owed" flags.
  logic [31:0] m_csr [NR];
  bit          m_wbusy, m_rbusy;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  logic [NR-1:0] m_wv;

  function automatic bit m_hit(input logic [31:0] a);
    if (a < BASE) return 0;
    if ((a - BASE) / 4 >= NR) return 0;
`ifdef BSG_AXIL_CSR_BANK_STRICT_ALIGN_EN
    if (a % 4 != 0) return 0;
`endif
    return 1;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // Model update on each clock from the stimulus the bench itself drives.
  always @(posedge clk) begin
    m_wv <= '0;
    if (reset) begin
      for (int i = 0; i < NR; i++) m_csr[i] <= '0;
      m_wbusy <= 0; m_rbusy <= 0;
      m_bresp <= '0; m_rresp <= '0; m_rdata <= '0;
    end else begin
      if (m_rbusy) begin
        if (rready) m_rbusy <= 0;
      end else if (arvalid) begin
        m_rbusy <= 1;
        m_rdata <= m_hit(araddr) ? m_csr[m_idx(araddr)] : 32'h0;
        m_rresp <= m_hit(araddr) ? 2'b00 : 2'b10;
      end
      if (m_wbusy) begin
        if (bready) m_wbusy <= 0;
      end else if (awvalid && wvalid) begin
        m_wbusy <= 1;
        m_bresp <= m_hit(awaddr) ? 2'b00 : 2'b10;
        if (m_hit(awaddr)) begin
          m_wv[m_idx(awaddr)] <= 1'b1;
          for (int k = 0; k < 4; k++)
            if (wstrb[k]) m_csr[m_idx(awaddr)][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  bit chk_en = 0;
  logic [NR*DW-1:0] m_flat;

  // Every-cycle compare of all DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NR; i++) m_flat[i*DW +: DW] = m_csr[i];
      chk("csr_o", csr_o, m_flat);
      chk("csr_w_v_o", csr_w_v_o, m_wv);
      chk("awready", awready, !m_wbusy && awvalid && wvalid);
      chk("wready", wready, !m_wbusy && awvalid && wvalid);
      chk("arready", arready, !m_rbusy);
      chk("bvalid", bvalid, m_wbusy);
      chk("bresp", bresp, m_bresp);
      chk("rvalid", rvalid, m_rbusy);
      chk("rresp", rresp, m_rresp);
      chk("rdata", rdata, m_rdata);
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [NR-1:0] wv);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    @(negedge clk);
    chk("wr_awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("wr_bvalid", bvalid, 1);
    resp = bresp; wv = csr_w_v_o;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    @(negedge clk);
    chk("rd_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 0;
    @(negedge clk);
    chk("rd_rvalid", rvalid, 1);
    d = rdata; resp = rresp;
  endtask

  logic [31:0] rd;
  logic [1:0]  rr, br;
  logic [NR-1:0] wv;

  initial begin
    @(posedge clk); #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset_csr", csr_o, '0);

    do_read(32'h0C, rd, rr);
    chk("t1_rdata", rd, 32'h0); chk("t1_rresp", rr, 2'b00);

    do_write(32'h08, 32'hDEADBEEF, 4'b1111, br, wv);
    chk("t2_bresp", br, 2'b00); chk("t2_wv", wv, 8'b0000_0100);
    chk("t2_csr2", csr_o[95:64], 32'hDEADBEEF);

    do_write(32'h08, 32'h11223344, 4'b0101, br, wv);
    do_read(32'h08, rd, rr);
    chk("t3_rdata", rd, 32'hDE22BE44);

    do_write(32'h20, 32'hCAFEF00D, 4'b1111, br, wv);
    chk("t4_bresp", br, 2'b10); chk("t4_wv", wv, 8'b0);
    do_read(32'h40, rd, rr);
    chk("t4_rresp", rr, 2'b10); chk("t4_rdata", rd, 32'h0);

    do_write(32'h10, 32'hFFFFFFFF, 4'b0000, br, wv);
    chk("zstrb_wv", wv, 8'b0001_0000); chk("zstrb_csr4", csr_o[159:128], 32'h0);

    // AW alone is held off, then backpressured B.
    @(posedge clk); #1;
    awaddr = 32'h1C; wdata = 32'hA5A50001; wstrb = 4'hF; awvalid = 1; bready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("aw_alone_awready", awready, 0); chk("aw_alone_wready", wready, 0);
    end
    @(posedge clk); #1 wvalid = 1;
    @(negedge clk); chk("aw_w_ready", awready, 1);
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_bvalid", bvalid, 1); chk("bp_awready", awready, 0);
    end
    chk("bp_csr7", csr_o[255:224], 32'hA5A50001);
    @(posedge clk); #1 bready = 1; awvalid = 0; wvalid = 0;
    @(negedge clk); chk("bp_bvalid_last", bvalid, 1);

    // Same-cycle write and read of CSR 1.
    @(posedge clk); #1;
    awaddr = 32'h04; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h04; arvalid = 1;
    @(negedge clk); chk("sc_awready", awready, 1); chk("sc_arready", arready, 1);
    @(posedge clk); #1 awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    chk("sc_rdata_old", rdata, 32'h0); chk("sc_csr1_new", csr_o[63:32], 32'h5);

    // Unaligned access to 0x06.
    do_read(32'h06, rd, rr);
`ifdef BSG_AXIL_CSR_BANK_STRICT_ALIGN_EN
    chk("ua_rresp", rr, 2'b10); chk("ua_rdata", rd, 32'h0);
`else
    chk("ua_rresp", rr, 2'b00); chk("ua_rdata", rd, 32'h5);
`endif
    do_write(32'h06, 32'h77, 4'hF, br, wv);
`ifdef BSG_AXIL_CSR_BANK_STRICT_ALIGN_EN
    chk("ua_bresp", br, 2'b10); chk("ua_csr1", csr_o[63:32], 32'h5);
`else
    chk("ua_bresp", br, 2'b00); chk("ua_csr1", csr_o[63:32], 32'h77);
`endif

    // Reset while a B response is pending drops it.
    @(posedge clk); #1;
    awaddr = 32'h18; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk); chk("rst_awready", awready, 1);
    @(posedge clk); #1 awvalid = 0; wvalid = 0; reset = 1;
    @(posedge clk); #1 reset = 0; bready = 1;
    @(negedge clk);
    chk("rst_bvalid", bvalid, 0); chk("rst_csr", csr_o, '0); chk("rst_bresp", bresp, 2'b00);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
